msrv32_pc_unit: RTL and testbench
=================================

MSRV32_PC_UNIT -- requirements
Module: msrv32_pc_unit

Interface
REQ-001 Parameter WIDTH, 32, datapath width of PC and addresses.
REQ-002 Parameter BOOT_ADDR, 32'h0000_0000, PC value loaded on reset.
REQ-003 clk_in  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n_in  input  1  reset, asynchronous, active-low.
REQ-005 branch_taken_in  input  1  redirect request from branch unit (conditional branch, JAL, JALR).
REQ-006 iaddr_in  input  WIDTH  branch/jump target from immediate adder.
REQ-007 trap_taken_in  input  1  trap entry request from CSR/machine-control.
REQ-008 trap_addr_in  input  WIDTH  trap vector address.
REQ-009 mret_in  input  1  return-from-trap request.
REQ-010 epc_in  input  WIDTH  saved exception PC.
REQ-011 i_ready_in  input  1  instruction memory has returned instruction at i_addr_out this cycle.
REQ-012 stall_in  input  1  downstream hold; blocks PC advance.
REQ-013 pc_out  output  WIDTH  PC of instruction currently executing (registered).
REQ-014 pc_plus_4_out  output  WIDTH  pc_out + 4, link value for JAL/JALR.
REQ-015 i_addr_out  output  WIDTH  instruction fetch address, equals pc_out.
REQ-016 i_req_out  output  1  fetch request, registered-state decode.
REQ-017 instr_valid_out  output  1  instruction at pc_out is accepted and retires this cycle.
REQ-018 misaligned_instr_out  output  1  registered flag: taken target not 4-byte aligned.

Function
REQ-019 FSM states SHALL be BOOT, RUN, HOLD; encoding free.
REQ-020 BOOT: i_req_out=0, instr_valid_out=0; unconditional transition to RUN next cycle.
REQ-021 RUN: i_req_out=1; advance = i_ready_in & ~stall_in; instr_valid_out = advance (combinational).
REQ-022 Effective target = {iaddr_in[WIDTH-1:1], 1'b0} (LSB cleared per JALR rule).
REQ-023 Next-PC priority SHALL be: trap_taken_in > mret_in > branch_taken_in > pc_out+4.
REQ-024 trap_taken_in in RUN or HOLD: pc_out <= trap_addr_in next cycle, regardless of i_ready_in/stall_in; misaligned_instr_out <= 0; state -> RUN.
REQ-025 mret_in (no trap) in RUN: pc_out <= epc_in next cycle, regardless of i_ready_in/stall_in.
REQ-026 branch_taken_in in RUN applies only on advance; target bit1=0: pc_out <= target; target bit1=1: pc_out unchanged, misaligned_instr_out <= 1, state -> HOLD.
REQ-027 No redirect in RUN: on advance pc_out <= pc_out+4; no advance: pc_out holds.
REQ-028 HOLD: i_req_out=0, instr_valid_out=0, pc_out holds, misaligned_instr_out stays 1 until trap_taken_in; mret_in and branch_taken_in ignored.
REQ-029 BOOT ignores trap_taken_in, mret_in, branch_taken_in.
REQ-030 All PC arithmetic modulo 2^WIDTH; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no flag.
REQ-031 pc_plus_4_out = pc_out + 4 combinationally, same wrap rule.
REQ-032 trap_addr_in and epc_in loaded verbatim, no alignment check.
REQ-033 One PC update per cycle maximum; latency from redirect input to new pc_out is exactly one clock.

Reset
REQ-034 rst_n_in low SHALL immediately (no clock) force pc_out=BOOT_ADDR, state=BOOT, misaligned_instr_out=0, i_req_out=0, instr_valid_out=0.
REQ-035 Reset asserted mid-fetch or in HOLD SHALL abandon the fetch with no further request; first request occurs the cycle after BOOT.
REQ-036 Reset deassertion is synchronised externally; block samples first state change on the first rising edge with rst_n_in high.

Verification
REQ-037 Reset release, i_ready_in=1, stall_in=0, no redirects -> cycle 1 i_req_out=0, then pc_out 0x0,0x4,0x8,0xC with instr_valid_out=1 each RUN cycle.
REQ-038 pc_out=0x100, branch_taken_in=1, iaddr_in=0x201, i_ready_in=1 -> next pc_out=0x200; same with i_ready_in=0 for 2 cycles -> pc_out holds 0x100 until ready.
REQ-039 pc_out=0x40, branch_taken_in=1, iaddr_in=0x46 -> misaligned_instr_out=1, pc_out=0x40, i_req_out=0; then trap_taken_in=1, trap_addr_in=0x80 -> pc_out=0x80, flag cleared, RUN.
REQ-040 Same cycle trap_taken_in=1 (0x80), mret_in=1 (epc 0x300), branch_taken_in=1 (0x500), stall_in=1 -> pc_out=0x80.
REQ-041 pc_out=0xFFFF_FFFC, advance -> pc_out=0x0, pc_plus_4_out=0x4.
REQ-042 rst_n_in pulsed low between clock edges while in RUN at pc 0x24 -> pc_out=0x0 and i_req_out=0 before next edge; BOOT then RUN.

Source files
------------

// File: rtl/msrv32_pc_unit_if.sv
// Program-counter unit interface: redirect requests, fetch handshake and PC
// outputs. The slave modport belongs to the PC unit and the master modport
// to the core or testbench that drives it.
//   inputs to PC unit : branch_taken_in, iaddr_in, trap_taken_in, trap_addr_in,
//                       mret_in, epc_in, i_ready_in, stall_in
//   outputs of PC unit: pc_out, pc_plus_4_out, i_addr_out, i_req_out,
//                       instr_valid_out, misaligned_instr_out
interface msrv32_pc_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             branch_taken_in;
  logic [WIDTH-1:0] iaddr_in;
  logic             trap_taken_in;
  logic [WIDTH-1:0] trap_addr_in;
  logic             mret_in;
  logic [WIDTH-1:0] epc_in;
  logic             i_ready_in;
  logic             stall_in;
  logic [WIDTH-1:0] pc_out;
  logic [WIDTH-1:0] pc_plus_4_out;
  logic [WIDTH-1:0] i_addr_out;
  logic             i_req_out;
  logic             instr_valid_out;
  logic             misaligned_instr_out;

  modport master (
    output branch_taken_in, iaddr_in, trap_taken_in, trap_addr_in,
           mret_in, epc_in, i_ready_in, stall_in,
    input  pc_out, pc_plus_4_out, i_addr_out, i_req_out,
           instr_valid_out, misaligned_instr_out
  );

  modport slave (
    input  branch_taken_in, iaddr_in, trap_taken_in, trap_addr_in,
           mret_in, epc_in, i_ready_in, stall_in,
    output pc_out, pc_plus_4_out, i_addr_out, i_req_out,
           instr_valid_out, misaligned_instr_out
  );
endinterface

// File: rtl/msrv32_pc_unit.sv
// Program counter and fetch-request control for the msrv32 core.
// Ports:
//   clk_in   - single clock, rising edge
//   rst_n_in - asynchronous active-low reset
//   bus      - msrv32_pc_unit_if.slave (redirects, fetch handshake, PC outputs)
// States: BOOT (one idle cycle after reset), RUN (fetching), HOLD (parked on a
// misaligned taken target until a trap arrives).
module msrv32_pc_unit #(
  parameter int unsigned     WIDTH     = 32,
  parameter logic [WIDTH-1:0] BOOT_ADDR = '0
) (
  input logic               clk_in,
  input logic               rst_n_in,
  msrv32_pc_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             mis_q, mis_d;
  logic [WIDTH-1:0] pc_plus_4;
  logic [WIDTH-1:0] target;
  logic             advance;

  assign pc_plus_4 = pc_q + WIDTH'(4);
  // Bit 0 of every jump target is dropped, as JALR requires.
  assign target    = bus.iaddr_in & ~WIDTH'(1);
  assign advance   = bus.i_ready_in & ~bus.stall_in;

  // State, PC and misalignment flag registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= BOOT;
      pc_q    <= BOOT_ADDR;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
    end
  end

  // Next-state, next-PC and fetch/retire decode.
  always_comb begin
    state_d             = state_q;
    pc_d                = pc_q;
    mis_d               = mis_q;
    bus.i_req_out       = 1'b0;
    bus.instr_valid_out = 1'b0;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        bus.i_req_out       = 1'b1;
        bus.instr_valid_out = advance;
        if (bus.trap_taken_in) begin
          pc_d  = bus.trap_addr_in;
          mis_d = 1'b0;
        end else if (bus.mret_in) begin
          pc_d = bus.epc_in;
        end else if (advance) begin
          if (bus.branch_taken_in) begin
            // A target with bit 1 set cannot be fetched: park in HOLD.
            if (target[1]) begin
              mis_d   = 1'b1;
              state_d = HOLD;
            end else begin
              pc_d = target;
            end
          end else begin
            pc_d = pc_plus_4;
          end
        end
      end
      HOLD: begin
        if (bus.trap_taken_in) begin
          pc_d    = bus.trap_addr_in;
          mis_d   = 1'b0;
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign bus.pc_out               = pc_q;
  assign bus.i_addr_out           = pc_q;
  assign bus.pc_plus_4_out        = pc_plus_4;
  assign bus.misaligned_instr_out = mis_q;

endmodule

// File: tb/tb_msrv32_pc_unit.sv
module tb_msrv32_pc_unit;

  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;

  msrv32_pc_unit_if #(.WIDTH(32)) bus ();

  msrv32_pc_unit #(.WIDTH(32), .BOOT_ADDR(32'h0000_0000)) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .bus      (bus.slave)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    string       name;
    logic        br;
    logic [31:0] iaddr;
    logic        trap;
    logic [31:0] taddr;
    logic        mret;
    logic [31:0] epc;
    logic        rdy;
    logic        stall;
    logic        exp_req;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        mis;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(string name, logic br, logic [31:0] iaddr,
                              logic trap, logic [31:0] taddr, logic mret,
                              logic [31:0] epc, logic rdy, logic stall,
                              logic exp_req, logic exp_valid,
                              logic [31:0] exp_pc, logic exp_mis);
    vec_t v;
    v.name = name; v.br = br; v.iaddr = iaddr; v.trap = trap; v.taddr = taddr;
    v.mret = mret; v.epc = epc; v.rdy = rdy; v.stall = stall;
    v.exp_req = exp_req; v.exp_valid = exp_valid;
    v.exp_pc = exp_pc; v.exp_mis = exp_mis;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge, check the decode seen in
  // that cycle, then check the registered result one step after the rising edge.
  task automatic apply(vec_t v);
    exp_t e;
    @(negedge clk_in);
    bus.branch_taken_in = v.br;
    bus.iaddr_in        = v.iaddr;
    bus.trap_taken_in   = v.trap;
    bus.trap_addr_in    = v.taddr;
    bus.mret_in         = v.mret;
    bus.epc_in          = v.epc;
    bus.i_ready_in      = v.rdy;
    bus.stall_in        = v.stall;
    e.name = v.name; e.pc = v.exp_pc; e.mis = v.exp_mis;
    sbq.push_back(e);
    #1;
    chk({v.name, ".i_req"}, 32'(bus.i_req_out), 32'(v.exp_req));
    chk({v.name, ".valid"}, 32'(bus.instr_valid_out), 32'(v.exp_valid));
    @(posedge clk_in);
    #1;
    if (sbq.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s.scoreboard: got empty queue expected entry", v.name);
    end else begin
      e = sbq.pop_front();
      chk({e.name, ".pc"}, bus.pc_out, e.pc);
      chk({e.name, ".i_addr"}, bus.i_addr_out, e.pc);
      chk({e.name, ".pc4"}, bus.pc_plus_4_out, e.pc + 32'd4);
      chk({e.name, ".mis"}, 32'(bus.misaligned_instr_out), 32'(e.mis));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.branch_taken_in = 1'b0; bus.iaddr_in = '0;
    bus.trap_taken_in = 1'b0;   bus.trap_addr_in = '0;
    bus.mret_in = 1'b0;         bus.epc_in = '0;
    bus.i_ready_in = 1'b1;      bus.stall_in = 1'b0;

    //          name      br  iaddr        trap taddr        mret epc          rdy st  req val exp_pc       mis
    vecs.push_back(mk("boot",   0, 32'h0,       1, 32'h999,      0, 32'h0,       1, 0,  0, 0, 32'h0,       0));
    vecs.push_back(mk("seq4",   0, 32'h0,       0, 32'h0,        0, 32'h0,       1, 0,  1, 1, 32'h4,       0));
    vecs.push_back(mk("seq8",   0, 32'h0,       0, 32'h0,        0, 32'h0,       1, 0,  1, 1, 32'h8,       0));
    vecs.push_back(mk("seqc",   0, 32'h0,       0, 32'h0,        0, 32'h0,       1, 0,  1, 1, 32'hC,       0));
    vecs.push_back(mk("trap100",0, 32'h0,       1, 32'h100,      0, 32'h0,       0, 1,  1, 0, 32'h100,     0));
    vecs.push_back(mk("brwait1",1, 32'h201,     0, 32'h0,        0, 32'h0,       0, 0,  1, 0, 32'h100,     0));
    vecs.push_back(mk("brwait2",1, 32'h201,     0, 32'h0,        0, 32'h0,       0, 0,  1, 0, 32'h100,     0));
    vecs.push_back(mk("br200",  1, 32'h201,     0, 32'h0,        0, 32'h0,       1, 0,  1, 1, 32'h200,     0));
    vecs.push_back(mk("stall",  0, 32'h0,       0, 32'h0,        0, 32'h0,       1, 1,  1, 0, 32'h200,     0));
    vecs.push_back(mk("mret",   0, 32'h0,       0, 32'h0,        1, 32'h303,     0, 0,  1, 0, 32'h303,     0));
    vecs.push_back(mk("trap40", 0, 32'h0,       1, 32'h40,       0, 32'h0,       1, 0,  1, 1, 32'h40,      0));
    vecs.push_back(mk("brmis",  1, 32'h46,      0, 32'h0,        0, 32'h0,       1, 0,  1, 1, 32'h40,      1));
    vecs.push_back(mk("hold",   1, 32'h100,     0, 32'h0,        1, 32'h500,     1, 0,  0, 0, 32'h40,      1));
    vecs.push_back(mk("htrap",  0, 32'h0,       1, 32'h80,       0, 32'h0,       1, 0,  0, 0, 32'h80,      0));
    vecs.push_back(mk("run84",  0, 32'h0,       0, 32'h0,        0, 32'h0,       1, 0,  1, 1, 32'h84,      0));
    vecs.push_back(mk("prio",   1, 32'h500,     1, 32'h80,       1, 32'h300,     1, 1,  1, 0, 32'h80,      0));
    vecs.push_back(mk("mretbr", 1, 32'h700,     0, 32'h0,        1, 32'h600,     1, 0,  1, 1, 32'h600,     0));
    vecs.push_back(mk("trapfc", 0, 32'h0,       1, 32'hFFFF_FFFC,0, 32'h0,       1, 0,  1, 1, 32'hFFFF_FFFC,0));
    vecs.push_back(mk("wrap",   0, 32'h0,       0, 32'h0,        0, 32'h0,       1, 0,  1, 1, 32'h0,       0));
    vecs.push_back(mk("trap24", 0, 32'h0,       1, 32'h24,       0, 32'h0,       1, 0,  1, 1, 32'h24,      0));

    // Reset state, asserted without any clock edge.
    #2;
    chk("rst.pc", bus.pc_out, 32'h0);
    chk("rst.i_req", 32'(bus.i_req_out), 32'h0);
    chk("rst.valid", 32'(bus.instr_valid_out), 32'h0);
    chk("rst.mis", 32'(bus.misaligned_instr_out), 32'h0);
    chk("rst.pc4", bus.pc_plus_4_out, 32'h4);
    @(posedge clk_in);
    #1 rst_n_in = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Reset pulsed between edges while running at 0x24.
    #2 rst_n_in = 1'b0;
    #1;
    chk("midrst.pc", bus.pc_out, 32'h0);
    chk("midrst.i_req", 32'(bus.i_req_out), 32'h0);
    chk("midrst.valid", 32'(bus.instr_valid_out), 32'h0);
    chk("midrst.mis", 32'(bus.misaligned_instr_out), 32'h0);
    @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    apply(mk("rboot", 0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 0, 0, 0, 32'h0, 0));
    apply(mk("rrun",  0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 0, 1, 1, 32'h4, 0));

    // Reset while parked in HOLD clears the flag and restarts from BOOT.
    apply(mk("hmis",  1, 32'h12, 0, 32'h0, 0, 32'h0, 1, 0, 1, 1, 32'h4, 1));
    #2 rst_n_in = 1'b0;
    #1;
    chk("hrst.mis", 32'(bus.misaligned_instr_out), 32'h0);
    chk("hrst.pc", bus.pc_out, 32'h0);
    @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    apply(mk("hboot", 0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 0, 0, 0, 32'h0, 0));
    apply(mk("hrun",  0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 0, 1, 1, 32'h4, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
